// File: rtl/riscv_wb_arbiter_if.sv
// Bus bundle for the WB write-port arbiter: pipeline WB inputs, long-latency result handshake,
// register-file write port and status outputs.
interface riscv_wb_arbiter_if #(
   parameter int unsigned FIFO_DEPTH = 4
);
   localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;

   logic          i_riscv_mw_regw_wb;
   logic [4:0]    i_riscv_mw_rdaddr_wb;
   logic [63:0]   i_riscv_mw_wbdata;
   logic          i_riscv_mw_lreq_valid;
   logic          o_riscv_mw_lreq_ready;
   logic [4:0]    i_riscv_mw_lreq_rdaddr;
   logic [63:0]   i_riscv_mw_lreq_data;
   logic          o_riscv_mw_rf_we;
   logic [4:0]    o_riscv_mw_rf_addr;
   logic [63:0]   o_riscv_mw_rf_data;
   logic          o_riscv_mw_stall;
   logic [PW-1:0] o_riscv_mw_pending;

   modport master (
      output i_riscv_mw_regw_wb, i_riscv_mw_rdaddr_wb, i_riscv_mw_wbdata,
      output i_riscv_mw_lreq_valid, i_riscv_mw_lreq_rdaddr, i_riscv_mw_lreq_data,
      input  o_riscv_mw_lreq_ready, o_riscv_mw_rf_we, o_riscv_mw_rf_addr, o_riscv_mw_rf_data,
      input  o_riscv_mw_stall, o_riscv_mw_pending
   );

   modport slave (
      input  i_riscv_mw_regw_wb, i_riscv_mw_rdaddr_wb, i_riscv_mw_wbdata,
      input  i_riscv_mw_lreq_valid, i_riscv_mw_lreq_rdaddr, i_riscv_mw_lreq_data,
      output o_riscv_mw_lreq_ready, o_riscv_mw_rf_we, o_riscv_mw_rf_addr, o_riscv_mw_rf_data,
      output o_riscv_mw_stall, o_riscv_mw_pending
   );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// Shares the WB register-file write port between the pipeline and queued long-latency results.
// Optional same-cycle bypass of an empty queue is enabled by defining RISCV_WB_BYPASS_EN.
module riscv_wb_arbiter #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic               i_riscv_mw_clk,
   input logic               i_riscv_mw_rst,
   riscv_wb_arbiter_if.slave wb_if
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT) + 1;
   localparam logic [PW-1:0] FULL       = PW'(FIFO_DEPTH);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

   typedef enum logic [1:0] {StIdle, StWait, StForce} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [4:0]    mem_addr_q [FIFO_DEPTH];
   logic [4:0]    mem_addr_d [FIFO_DEPTH];
   logic [63:0]   mem_data_q [FIFO_DEPTH];
   logic [63:0]   mem_data_d [FIFO_DEPTH];

   logic pipe_busy;
   logic empty;
   logic ready;
   logic lreq_nz;
   logic bypass;
   logic enq;
   logic deq;

   assign pipe_busy = wb_if.i_riscv_mw_regw_wb && (wb_if.i_riscv_mw_rdaddr_wb != 5'd0);
   assign empty     = (cnt_q == '0);
   assign ready     = (cnt_q != FULL);
   assign lreq_nz   = wb_if.i_riscv_mw_lreq_rdaddr != 5'd0;

`ifdef RISCV_WB_BYPASS_EN
   assign bypass = empty && !pipe_busy && wb_if.i_riscv_mw_lreq_valid && lreq_nz;
`else
   assign bypass = 1'b0;
`endif

   // x0 results complete the handshake but are dropped here.
   assign enq = wb_if.i_riscv_mw_lreq_valid && ready && lreq_nz && !bypass;
   assign deq = !pipe_busy && !empty;

   // Queue storage and pointers
   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (enq) begin
         mem_addr_d[wr_ptr_q] = wb_if.i_riscv_mw_lreq_rdaddr;
         mem_data_d[wr_ptr_q] = wb_if.i_riscv_mw_lreq_data;
         wr_ptr_d             = wr_ptr_q + AW'(1);
      end
      if (deq) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      unique case ({enq, deq})
         2'b10:   cnt_d = cnt_q + PW'(1);
         2'b01:   cnt_d = cnt_q - PW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Starvation FSM
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      unique case (state_q)
         StIdle: begin
            if (enq) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (deq) begin
               starve_d = '0;
            end else begin
               starve_d = starve_q + SW'(1);
            end
            if (cnt_d == '0) begin
               state_d = StIdle;
            end else if ((!deq && (starve_q == STARVE_MAX)) || (cnt_q == FULL)) begin
               state_d = StForce;
            end
         end
         StForce: begin
            // A still-busy pipeline keeps priority; hold here until the bubble lands.
            if (deq) begin
               starve_d = '0;
               state_d  = (cnt_d == '0) ? StIdle : StWait;
            end
         end
         default: begin
            state_d  = StIdle;
            starve_d = '0;
         end
      endcase
   end

   always_ff @(posedge i_riscv_mw_clk or posedge i_riscv_mw_rst) begin
      if (i_riscv_mw_rst) begin
         state_q  <= StIdle;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
      end
   end

   always_ff @(posedge i_riscv_mw_clk) begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
   end

   // Write-port mux: pipeline, then queue head, then optional bypass
   always_comb begin
      wb_if.o_riscv_mw_rf_we   = pipe_busy;
      wb_if.o_riscv_mw_rf_addr = wb_if.i_riscv_mw_rdaddr_wb;
      wb_if.o_riscv_mw_rf_data = wb_if.i_riscv_mw_wbdata;
      if (!pipe_busy) begin
         if (!empty) begin
            wb_if.o_riscv_mw_rf_we   = 1'b1;
            wb_if.o_riscv_mw_rf_addr = mem_addr_q[rd_ptr_q];
            wb_if.o_riscv_mw_rf_data = mem_data_q[rd_ptr_q];
         end else if (bypass) begin
            wb_if.o_riscv_mw_rf_we   = 1'b1;
            wb_if.o_riscv_mw_rf_addr = wb_if.i_riscv_mw_lreq_rdaddr;
            wb_if.o_riscv_mw_rf_data = wb_if.i_riscv_mw_lreq_data;
         end
      end
   end

   assign wb_if.o_riscv_mw_lreq_ready = ready;
   assign wb_if.o_riscv_mw_stall      = (state_q == StForce);
   assign wb_if.o_riscv_mw_pending    = cnt_q;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Self-checking bench for riscv_wb_arbiter: vector table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_riscv_wb_arbiter;
   localparam int unsigned D  = 4;
   localparam int unsigned L  = 8;
   localparam int unsigned PW = $clog2(D) + 1;
`ifdef RISCV_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   riscv_wb_arbiter_if #(.FIFO_DEPTH(D)) bus ();

   riscv_wb_arbiter #(
      .FIFO_DEPTH  (D),
      .STARVE_LIMIT(L)
   ) dut (
      .i_riscv_mw_clk(clk),
      .i_riscv_mw_rst(rst),
      .wb_if         (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic        in_regw;
   logic [4:0]  in_rd;
   logic [63:0] in_wd;
   logic        in_lv;
   logic [4:0]  in_lrd;
   logic [63:0] in_ld;

   // Reference model: a plain queue of results plus a starvation tally
   logic [4:0]  mq_addr [$];
   logic [63:0] mq_data [$];
   bit          m_forced;
   int unsigned m_starve;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic regw, input logic [4:0] rd, input logic [63:0] wd,
                         input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
      in_regw = regw; in_rd = rd; in_wd = wd; in_lv = lv; in_lrd = lrd; in_ld = ld;
      bus.i_riscv_mw_regw_wb     = regw;
      bus.i_riscv_mw_rdaddr_wb   = rd;
      bus.i_riscv_mw_wbdata      = wd;
      bus.i_riscv_mw_lreq_valid  = lv;
      bus.i_riscv_mw_lreq_rdaddr = lrd;
      bus.i_riscv_mw_lreq_data   = ld;
   endtask

   function automatic void model_reset();
      mq_addr.delete();
      mq_data.delete();
      m_forced = 1'b0;
      m_starve = 0;
   endfunction

   function automatic void model_step();
      bit busy, deq, byp, was_forced;
      int s, ns;
      busy = in_regw && (in_rd != 0);
      s    = mq_addr.size();
      deq  = !busy && (s > 0);
      byp  = BYP && (s == 0) && !busy && in_lv && (in_lrd != 0);
      if (deq) begin
         void'(mq_addr.pop_front());
         void'(mq_data.pop_front());
      end
      if (in_lv && (s != D) && (in_lrd != 0) && !byp) begin
         mq_addr.push_back(in_lrd);
         mq_data.push_back(in_ld);
      end
      ns         = mq_addr.size();
      was_forced = m_forced;
      if (!was_forced) begin
         if (s > 0 && ns != 0 && ((!deq && m_starve == L - 1) || s == D)) m_forced = 1'b1;
      end else if (deq) begin
         m_forced = 1'b0;
      end
      if (deq) m_starve = 0;
      else if (!was_forced && s > 0) m_starve++;
   endfunction

   task automatic compare_model();
      logic        we;
      logic [4:0]  a;
      logic [63:0] d;
      int          s;
      s  = mq_addr.size();
      we = 1'b0; a = in_rd; d = in_wd;
      if (in_regw && in_rd != 0) begin
         we = 1'b1;
      end else if (s > 0) begin
         we = 1'b1; a = mq_addr[0]; d = mq_data[0];
      end else if (BYP && in_lv && in_lrd != 0) begin
         we = 1'b1; a = in_lrd; d = in_ld;
      end
      check("rnd_rf_we", 64'(bus.o_riscv_mw_rf_we), 64'(we));
      check("rnd_rf_addr", 64'(bus.o_riscv_mw_rf_addr), 64'(a));
      check("rnd_rf_data", bus.o_riscv_mw_rf_data, d);
      check("rnd_ready", 64'(bus.o_riscv_mw_lreq_ready), 64'(s != D));
      check("rnd_stall", 64'(bus.o_riscv_mw_stall), 64'(m_forced));
      check("rnd_pending", 64'(bus.o_riscv_mw_pending), 64'(s));
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic        regw;
      logic [4:0]  rd;
      logic [63:0] wd;
      logic        lv;
      logic [4:0]  lrd;
      logic [63:0] ld;
      logic        we;
      logic [4:0]  addr;
      logic [63:0] data;
      logic        ready;
      logic        stall;
      logic [63:0] pend;
   } vec_t;

   function automatic vec_t mk(logic regw, logic [4:0] rd, logic [63:0] wd, logic lv,
                               logic [4:0] lrd, logic [63:0] ld, logic we, logic [4:0] addr,
                               logic [63:0] data, logic [63:0] pend);
      vec_t v;
      v.regw = regw; v.rd = rd; v.wd = wd; v.lv = lv; v.lrd = lrd; v.ld = ld;
      v.we = we; v.addr = addr; v.data = data; v.ready = 1'b1; v.stall = 1'b0; v.pend = pend;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      vec_t tv [13];
      tv[0]  = mk(1, 3, 64'h33, 1, 5, 64'hAAAA, 1, 3, 64'h33, 0);
      tv[1]  = mk(1, 3, 64'h34, 0, 0, 0, 1, 3, 64'h34, 1);
      tv[2]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 64'hAAAA, 1);
      tv[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tv[4]  = mk(1, 0, 64'h55, 1, 0, 64'h99, 0, 0, 64'h55, 0);
      tv[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (BYP) begin
         tv[6] = mk(0, 0, 0, 1, 7, 64'h1234, 1, 7, 64'h1234, 0);
         tv[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end else begin
         tv[6] = mk(0, 0, 0, 1, 7, 64'h1234, 0, 0, 0, 0);
         tv[7] = mk(0, 0, 0, 0, 0, 0, 1, 7, 64'h1234, 1);
      end
      tv[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tv[9]  = mk(1, 31, 64'hFFFF_0000_FFFF_0000, 1, 31, 64'h0123_4567_89AB_CDEF,
                  1, 31, 64'hFFFF_0000_FFFF_0000, 0);
      tv[10] = mk(1, 4, 64'h44, 0, 0, 0, 1, 4, 64'h44, 1);
      tv[11] = mk(0, 9, 64'h99, 0, 0, 0, 1, 31, 64'h0123_4567_89AB_CDEF, 1);
      tv[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      set_in(0, 0, 0, 0, 0, 0);
      apply_reset();

      // Reset state
      @(negedge clk);
      check("rst_pending", 64'(bus.o_riscv_mw_pending), 0);
      check("rst_stall", 64'(bus.o_riscv_mw_stall), 0);
      check("rst_ready", 64'(bus.o_riscv_mw_lreq_ready), 1);
      check("rst_rf_we", 64'(bus.o_riscv_mw_rf_we), 0);
      finish_cycle();

      // Vector table: priority, x0 handling, enqueue latency / bypass
      for (int i = 0; i < 13; i++) begin
         set_in(tv[i].regw, tv[i].rd, tv[i].wd, tv[i].lv, tv[i].lrd, tv[i].ld);
         @(negedge clk);
         check($sformatf("vec%0d_rf_we", i), 64'(bus.o_riscv_mw_rf_we), 64'(tv[i].we));
         check($sformatf("vec%0d_rf_addr", i), 64'(bus.o_riscv_mw_rf_addr), 64'(tv[i].addr));
         check($sformatf("vec%0d_rf_data", i), bus.o_riscv_mw_rf_data, tv[i].data);
         check($sformatf("vec%0d_ready", i), 64'(bus.o_riscv_mw_lreq_ready), 64'(tv[i].ready));
         check($sformatf("vec%0d_stall", i), 64'(bus.o_riscv_mw_stall), 64'(tv[i].stall));
         check($sformatf("vec%0d_pending", i), 64'(bus.o_riscv_mw_pending), tv[i].pend);
         finish_cycle();
      end

      // Full / backpressure
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         set_in(1, 1, 64'h100 + 64'(i), 1, 5'(10 + i), 64'hD0 + 64'(i));
         @(negedge clk);
         check($sformatf("full_ready%0d", i), 64'(bus.o_riscv_mw_lreq_ready), 64'(i < 4));
         check($sformatf("full_pending%0d", i), 64'(bus.o_riscv_mw_pending), 64'(i));
         check($sformatf("full_stall%0d", i), 64'(bus.o_riscv_mw_stall), 0);
         finish_cycle();
      end
      set_in(1, 1, 64'h200, 0, 0, 0);
      @(negedge clk);
      check("full_stall_up", 64'(bus.o_riscv_mw_stall), 1);
      check("full_ready_low", 64'(bus.o_riscv_mw_lreq_ready), 0);
      finish_cycle();
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("full_bubble_we", 64'(bus.o_riscv_mw_rf_we), 1);
      check("full_bubble_addr", 64'(bus.o_riscv_mw_rf_addr), 10);
      check("full_bubble_data", bus.o_riscv_mw_rf_data, 64'hD0);
      finish_cycle();
      set_in(1, 1, 64'h201, 0, 0, 0);
      @(negedge clk);
      check("full_after_stall", 64'(bus.o_riscv_mw_stall), 0);
      check("full_after_ready", 64'(bus.o_riscv_mw_lreq_ready), 1);
      check("full_after_pending", 64'(bus.o_riscv_mw_pending), 3);
      finish_cycle();
      for (int j = 0; j < 3; j++) begin
         set_in(0, 0, 0, 0, 0, 0);
         @(negedge clk);
         check($sformatf("drain_addr%0d", j), 64'(bus.o_riscv_mw_rf_addr), 64'(11 + j));
         check($sformatf("drain_data%0d", j), bus.o_riscv_mw_rf_data, 64'hD1 + 64'(j));
         finish_cycle();
      end
      @(negedge clk);
      check("drain_pending", 64'(bus.o_riscv_mw_pending), 0);
      finish_cycle();

      // Starvation
      apply_reset();
      set_in(1, 2, 64'h22, 1, 9, 64'hBEEF);
      @(negedge clk);
      check("starve_pending0", 64'(bus.o_riscv_mw_pending), 0);
      finish_cycle();
      for (int k = 1; k <= 10; k++) begin
         set_in(1, 2, 64'h22 + 64'(k), 0, 0, 0);
         @(negedge clk);
         check($sformatf("starve_stall%0d", k), 64'(bus.o_riscv_mw_stall), 64'(k >= 9));
         check($sformatf("starve_pending%0d", k), 64'(bus.o_riscv_mw_pending), 1);
         finish_cycle();
      end
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("starve_retire_addr", 64'(bus.o_riscv_mw_rf_addr), 9);
      check("starve_retire_data", bus.o_riscv_mw_rf_data, 64'hBEEF);
      check("starve_retire_stall", 64'(bus.o_riscv_mw_stall), 1);
      finish_cycle();
      @(negedge clk);
      check("starve_clear_stall", 64'(bus.o_riscv_mw_stall), 0);
      check("starve_clear_we", 64'(bus.o_riscv_mw_rf_we), 0);
      finish_cycle();

      // Asynchronous reset with three entries queued
      for (int i = 0; i < 3; i++) begin
         set_in(1, 6, 64'h60, 1, 5'(20 + i), 64'hE0 + 64'(i));
         finish_cycle();
      end
      @(negedge clk);
      check("mid_pending_pre", 64'(bus.o_riscv_mw_pending), 3);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("mid_rst_pending", 64'(bus.o_riscv_mw_pending), 0);
      check("mid_rst_stall", 64'(bus.o_riscv_mw_stall), 0);
      check("mid_rst_ready", 64'(bus.o_riscv_mw_lreq_ready), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         set_in(0, 0, 0, 0, 0, 0);
         @(negedge clk);
         check($sformatf("mid_post_we%0d", j), 64'(bus.o_riscv_mw_rf_we), 0);
         finish_cycle();
      end

      // Randomized traffic against the reference model
      apply_reset();
      begin
         int unsigned busy_pct = 50;
         for (int c = 0; c < 3000; c++) begin
            logic [4:0] rd, lrd;
            if (c % 64 == 0) busy_pct = ($urandom_range(0, 2) == 0) ? 95 :
                                        ($urandom_range(0, 1) == 0) ? 70 : 30;
            if ($urandom_range(0, 499) == 0) apply_reset();
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            set_in($urandom_range(0, 99) < busy_pct, rd, {$urandom, $urandom},
                   $urandom_range(0, 99) < 45, lrd, {$urandom, $urandom});
            @(negedge clk);
            compare_model();
            finish_cycle();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
